// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: latch command encoding, the per-latch command
// bundle with its canonical patterns, and the hazard FSM state type.
package pipe_pkg;

  typedef enum logic [1:0] {
    CTR_NORMAL = 2'b00,
    CTR_SQUASH = 2'b01,
    CTR_STALL  = 2'b10
  } ctr_t;

  typedef struct packed {
    logic pc_en;
    ctr_t ifid;
    ctr_t idex;
    ctr_t exmem;
    ctr_t memwb;
  } lat_cmd_t;

  typedef enum logic {
    StRun,
    StMc
  } hz_state_e;

  localparam lat_cmd_t CmdNormal = '{
    pc_en: 1'b1, ifid: CTR_NORMAL, idex: CTR_NORMAL, exmem: CTR_NORMAL, memwb: CTR_NORMAL
  };

  localparam lat_cmd_t CmdReset = '{
    pc_en: 1'b0, ifid: CTR_SQUASH, idex: CTR_SQUASH, exmem: CTR_SQUASH, memwb: CTR_SQUASH
  };

  // WB keeps its instruction: it is the one raising the exception.
  localparam lat_cmd_t CmdFlush = '{
    pc_en: 1'b1, ifid: CTR_SQUASH, idex: CTR_SQUASH, exmem: CTR_SQUASH, memwb: CTR_NORMAL
  };

  localparam lat_cmd_t CmdMemWait = '{
    pc_en: 1'b0, ifid: CTR_STALL, idex: CTR_STALL, exmem: CTR_STALL, memwb: CTR_SQUASH
  };

  // EX holds the multi-cycle op; a bubble drains into MEM each stall cycle.
  localparam lat_cmd_t CmdMcStall = '{
    pc_en: 1'b0, ifid: CTR_STALL, idex: CTR_STALL, exmem: CTR_SQUASH, memwb: CTR_NORMAL
  };

  localparam lat_cmd_t CmdBranch = '{
    pc_en: 1'b1, ifid: CTR_SQUASH, idex: CTR_SQUASH, exmem: CTR_NORMAL, memwb: CTR_NORMAL
  };

  localparam lat_cmd_t CmdLoadUse = '{
    pc_en: 1'b0, ifid: CTR_STALL, idex: CTR_SQUASH, exmem: CTR_NORMAL, memwb: CTR_NORMAL
  };

  function automatic logic cmd_is_stall(input lat_cmd_t cmd);
    return !cmd.pc_en;
  endfunction

endpackage

// File: rtl/pipe_mc_timer.sv
// Down-counter tracking the remaining stall cycles of a multi-cycle EX op.
// abort beats hold beats load; otherwise it counts down to zero and sticks.
module pipe_mc_timer
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic hold,
  input  logic abort,
  output logic last,
  output logic busy
);

  localparam int unsigned CntW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(MC_LAT - 2);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (abort) begin
      w_cnt_d = '0;
    end else if (hold) begin
      w_cnt_d = r_cnt;
    end else if (load) begin
      w_cnt_d = LoadVal;
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign last = (r_cnt == CntW'(1));
  assign busy = (r_cnt != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: priority mux producing the per-latch commands and
// PC enable, the RUN/MC FSM for multi-cycle EX ops, and a stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              mem_busy,
  input  logic              br_taken,
  input  logic              mc_start,
  input  logic              load_use,
  output logic              pc_en,
  output logic [1:0]        ctr_ifid,
  output logic [1:0]        ctr_idex,
  output logic [1:0]        ctr_exmem,
  output logic [1:0]        ctr_memwb,
  output logic              mc_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  hz_state_e         r_state;
  logic              r_mc_busy;
  logic [PERF_W-1:0] r_stall_cycles;

  lat_cmd_t w_cmd;
  logic     w_mc_go;
  logic     w_tmr_load;
  logic     w_tmr_hold;
  logic     w_tmr_last;
  logic     w_tmr_busy;

  // A branch in the same cycle as mc_start wins; the op is never started.
  assign w_mc_go    = (r_state == StRun) && mc_start && !br_taken;
  assign w_tmr_load = w_mc_go && !flush && !mem_busy;
  assign w_tmr_hold = mem_busy && !flush;

  pipe_mc_timer #(
    .MC_LAT (MC_LAT)
  ) u_mc_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_tmr_load),
    .hold  (w_tmr_hold),
    .abort (flush),
    .last  (w_tmr_last),
    .busy  (w_tmr_busy)
  );

  always_comb begin
    w_cmd = CmdNormal;
    if (!rst_n) begin
      w_cmd = CmdReset;
    end else if (flush) begin
      w_cmd = CmdFlush;
    end else if (mem_busy) begin
      w_cmd = CmdMemWait;
    end else if (r_state == StMc) begin
      w_cmd = CmdMcStall;
    end else if (br_taken) begin
      w_cmd = CmdBranch;
    end else if (mc_start) begin
      w_cmd = CmdMcStall;
    end else if (load_use) begin
      w_cmd = CmdLoadUse;
    end
  end

  assign pc_en     = w_cmd.pc_en;
  assign ctr_ifid  = w_cmd.ifid;
  assign ctr_idex  = w_cmd.idex;
  assign ctr_exmem = w_cmd.exmem;
  assign ctr_memwb = w_cmd.memwb;

  // mc_busy lingers one cycle past the last MC cycle, covering the op's
  // completion cycle in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StRun;
      r_mc_busy <= 1'b0;
    end else if (flush) begin
      r_state   <= StRun;
      r_mc_busy <= 1'b0;
    end else if (!mem_busy) begin
      unique case (r_state)
        StRun: begin
          if (w_mc_go && (MC_LAT > 2)) begin
            r_state   <= StMc;
            r_mc_busy <= 1'b1;
          end else begin
            r_mc_busy <= 1'b0;
          end
        end
        StMc: begin
          r_mc_busy <= 1'b1;
          if (w_tmr_last || !w_tmr_busy) begin
            r_state <= StRun;
          end
        end
        default: begin
          r_state   <= StRun;
          r_mc_busy <= 1'b0;
        end
      endcase
    end
  end

  assign mc_busy = r_mc_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (cmd_is_stall(w_cmd)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MC_LAT=4). Commands are checked
// as the packed word {pc_en, ifid, idex, exmem, memwb}.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] PNormal  = 9'h100;
  localparam logic [8:0] PReset   = 9'h055;
  localparam logic [8:0] PFlush   = 9'h154;
  localparam logic [8:0] PMemWait = 9'h0A9;
  localparam logic [8:0] PMc      = 9'h0A4;
  localparam logic [8:0] PBranch  = 9'h150;
  localparam logic [8:0] PLoadUse = 9'h090;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mem_busy;
  logic        br_taken;
  logic        mc_start;
  logic        load_use;
  logic        pc_en;
  logic [1:0]  ctr_ifid;
  logic [1:0]  ctr_idex;
  logic [1:0]  ctr_exmem;
  logic [1:0]  ctr_memwb;
  logic        mc_busy;
  logic [31:0] stall_cycles;
  logic [8:0]  w_cmd;

  int n_vec;
  int n_err;
  int n_viol;

  pipe_hazard_ctrl #(
    .MC_LAT (4),
    .PERF_W (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .mem_busy     (mem_busy),
    .br_taken     (br_taken),
    .mc_start     (mc_start),
    .load_use     (load_use),
    .pc_en        (pc_en),
    .ctr_ifid     (ctr_ifid),
    .ctr_idex     (ctr_idex),
    .ctr_exmem    (ctr_exmem),
    .ctr_memwb    (ctr_memwb),
    .mc_busy      (mc_busy),
    .stall_cycles (stall_cycles)
  );

  assign w_cmd = {pc_en, ctr_ifid, ctr_idex, ctr_exmem, ctr_memwb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      a_br_mc: assert (!(br_taken && mc_start)) else begin
        n_viol = n_viol + 1;
        $display("protocol violation: br_taken with mc_start at %0t", $time);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic mb, input logic br, input logic mc,
                       input logic lu);
    flush    = f;
    mem_busy = mb;
    br_taken = br;
    mc_start = mc;
    load_use = lu;
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    n_viol = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2;
    check_val("reset_cmd", 32'(w_cmd), 32'(PReset));
    check_val("reset_busy", 32'(mc_busy), 0);
    check_val("reset_stall", stall_cycles, 0);
    step();
    rst_n = 1'b1;
    step();
    drive(0, 0, 0, 0, 0);
    check_val("idle_cmd", 32'(w_cmd), 32'(PNormal));
    check_val("idle_stall", stall_cycles, 0);

    // Plain MC op: three stall cycles, release in the fourth.
    step(); drive(0, 0, 0, 1, 0);
    check_val("mc0_cmd", 32'(w_cmd), 32'(PMc));
    check_val("mc0_busy", 32'(mc_busy), 0);
    step(); drive(0, 0, 0, 0, 0);
    check_val("mc1_cmd", 32'(w_cmd), 32'(PMc));
    check_val("mc1_busy", 32'(mc_busy), 1);
    step();
    check_val("mc2_cmd", 32'(w_cmd), 32'(PMc));
    check_val("mc2_busy", 32'(mc_busy), 1);
    step();
    check_val("mc3_cmd", 32'(w_cmd), 32'(PNormal));
    check_val("mc3_busy", 32'(mc_busy), 1);
    check_val("mc_stall", stall_cycles, 3);
    step();
    check_val("mc4_busy", 32'(mc_busy), 0);

    // MC op with a MEM wait in its second cycle: stall extends by one.
    step(); drive(0, 0, 0, 1, 0);
    check_val("mcw0_cmd", 32'(w_cmd), 32'(PMc));
    step(); drive(0, 1, 0, 0, 0);
    check_val("mcw1_cmd", 32'(w_cmd), 32'(PMemWait));
    step(); drive(0, 0, 0, 0, 0);
    check_val("mcw2_cmd", 32'(w_cmd), 32'(PMc));
    step();
    check_val("mcw3_cmd", 32'(w_cmd), 32'(PMc));
    step();
    check_val("mcw4_cmd", 32'(w_cmd), 32'(PNormal));
    check_val("mcw4_busy", 32'(mc_busy), 1);
    check_val("mcw_stall", stall_cycles, 7);
    step();
    check_val("mcw5_busy", 32'(mc_busy), 0);

    // Load-use twice, then a branch alongside load_use.
    step(); drive(0, 0, 0, 0, 1);
    check_val("lu0_cmd", 32'(w_cmd), 32'(PLoadUse));
    step();
    check_val("lu1_cmd", 32'(w_cmd), 32'(PLoadUse));
    step(); drive(0, 0, 1, 0, 1);
    check_val("lubr_cmd", 32'(w_cmd), 32'(PBranch));
    step(); drive(0, 0, 0, 0, 0);
    check_val("lu_idle_cmd", 32'(w_cmd), 32'(PNormal));
    check_val("lu_stall", stall_cycles, 9);

    // Flush in the second cycle of an MC op aborts it.
    step(); drive(0, 0, 0, 1, 0);
    check_val("fl0_cmd", 32'(w_cmd), 32'(PMc));
    step(); drive(1, 0, 0, 0, 0);
    check_val("fl1_cmd", 32'(w_cmd), 32'(PFlush));
    check_val("fl1_busy", 32'(mc_busy), 1);
    step(); drive(0, 0, 0, 0, 0);
    check_val("fl2_cmd", 32'(w_cmd), 32'(PNormal));
    check_val("fl2_busy", 32'(mc_busy), 0);
    check_val("fl_stall", stall_cycles, 10);

    // Branch with mc_start: branch wins, FSM stays in RUN.
    step(); drive(0, 0, 1, 1, 0);
    check_val("brmc_cmd", 32'(w_cmd), 32'(PBranch));
    step(); drive(0, 0, 0, 0, 0);
    check_val("brmc_next_cmd", 32'(w_cmd), 32'(PNormal));
    check_val("brmc_busy", 32'(mc_busy), 0);
    check_val("brmc_viol", 32'(n_viol), 1);

    // MEM wait alone in RUN, then flush together with mem_busy.
    step(); drive(0, 1, 0, 0, 1);
    check_val("mw_cmd", 32'(w_cmd), 32'(PMemWait));
    step(); drive(0, 0, 0, 0, 0);
    check_val("mw_stall", stall_cycles, 11);
    step(); drive(1, 1, 0, 0, 0);
    check_val("flmw_cmd", 32'(w_cmd), 32'(PFlush));
    step(); drive(0, 0, 0, 0, 0);
    check_val("flmw_stall", stall_cycles, 11);

    // Reset asserted mid-MC abandons the op.
    step(); drive(0, 0, 0, 1, 0);
    step(); drive(0, 0, 0, 0, 0);
    check_val("rmc_cmd", 32'(w_cmd), 32'(PMc));
    rst_n = 1'b0;
    #1;
    check_val("rmc_rst_cmd", 32'(w_cmd), 32'(PReset));
    check_val("rmc_rst_busy", 32'(mc_busy), 0);
    check_val("rmc_rst_stall", stall_cycles, 0);
    step();
    rst_n = 1'b1;
    step();
    check_val("rmc_after_cmd", 32'(w_cmd), 32'(PNormal));
    step();
    check_val("rmc_after_busy", 32'(mc_busy), 0);
    check_val("rmc_after_stall", stall_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
